aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Parametrised iterative AES key schedule supporting 128/192/256-bit keys, generating one 32-bit schedule word per cycle from the shared S-box and Rcon tables. Accepts a cipher key over a valid/ready handshake and streams the Nr+1 128-bit round keys, in order, over a second valid/ready handshake. Sits between key load logic and the round pipeline of the AES core, replacing fixed AES-128 key handling.

## Interface
- KEY_BITS, 128, cipher key width; legal values 128, 192, 256; any other value is an elaboration error
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- key_valid  in  1  key_data valid
- key_ready  out  1  block idle, key accepted on key_valid && key_ready
- key_data  in  KEY_BITS  cipher key; key_data[KEY_BITS-1 -: 32] is w0 (FIPS-197 byte order, byte 0 in MSBs)
- rk_valid  out  1  round key valid
- rk_ready  in  1  consumer accepts round key
- rk_data  out  128  round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}
- rk_round  out  4  round index r, 0..Nr
- rk_last  out  1  high with round Nr

## Operation
- Nk = KEY_BITS/32, Nr = Nk+6, total words NW = 4*(Nr+1) (44/52/60).
- States: IDLE -> GEN on key handshake; GEN -> DRAIN when word NW-1 is written; DRAIN -> IDLE on handshake of round Nr.
- key_ready = (state == IDLE); rk_* outputs are registers.
- Word counter i (6 bit); companion counters i mod Nk and rcon index (no divider).
- Word i: i < Nk -> key word i; else w[i-Nk] ^ temp, temp = w[i-1]; if i mod Nk == 0: temp = SubWord(RotWord(temp)) ^ RCON[i/Nk - 1]; else if Nk == 8 and i mod Nk == 4: temp = SubWord(temp).
- Window: Nk-deep shift register of the most recent words (w[i-Nk] at the tail, w[i-1] at the head).
- Collector: 4-word register filling in order; when full it transfers to output register if output empty or being consumed that cycle, otherwise generation stalls (i, window, collector hold).
- Output register holds data until rk_valid && rk_ready; rk_round increments per transfer.
- key_valid in non-IDLE states is ignored; key_data sampled only on handshake.
- Reset (any state, mid-operation included): state IDLE, counters 0, rk_valid 0, rk_data 0, rk_round 0, rk_last 0; key_ready high the cycle after reset deasserts. Partial schedule discarded.

## Timing
- Handshake cycle T; words w0..w3 written at ends of T+1..T+4; round 0 valid in T+5.
- rk_ready held high: round r valid at T+5+4r, one round key per 4 cycles; final key at T+5+4Nr (T+45 / T+53 / T+61).
- Final handshake at cycle F -> key_ready high at F+1; earliest next key handshake F+1.
- Backpressure: generation runs ahead at most 4 words (one collector) beyond the output register; no data loss or reordering under any rk_ready pattern.
- rk_valid never drops without a handshake; rk_data/rk_round/rk_last stable while rk_valid && !rk_ready.

## Structure
- aes_model_pack: SUB_BYTES_TABLE, RCON_TABLE (10 entries, index 0 = 8'h01), functions nk(KEY_BITS), nr(KEY_BITS), word typedef (logic [31:0]), state enum.
- Sub-module aes_sub_word: combinational 4-byte S-box lookup via SUB_BYTES_TABLE; instantiated once, shared between RotWord and Nk==8 paths via mux.

## Test plan
- KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> round 1 a0fafe1788542cb123a339392a6c7605, round 10 d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1 at T+45.
- KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> w6 fe0c91f7; round 12 e98ba06f448c773c8ecc720401002202, rk_last=1.
- KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> w8 9ba35411 (round 2 word 0); round 14 fe4890d1e6188d0b046df344706c631e.
- Random rk_ready (50%) on the 128-bit vector -> identical 11-key sequence, rk_* stable during stalls, no duplicates/drops.
- Assert rst during round 5 output -> next cycle rk_valid=0, key_ready=1; fresh key gives correct round 0 at T+5.
- key_valid held high through a full schedule with changing key_data -> only first key used; second accepted at F+1 and its schedule correct.

Source files
------------

// File: rtl/aes_key_expander_pkg.sv
// Shared definitions for the iterative AES key schedule.
//   SUB_BYTES_TABLE : AES forward S-box, entry 0 at index 0
//   RCON_TABLE      : round constants, index 0 = 8'h01
//   nk(), nr()      : key length in words and round count for a key width
//   word_t          : 32-bit schedule word
//   state_t         : control states of the expander
package aes_model_pack;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GEN,
    ST_DRAIN
  } state_t;

  // Packed with index 0 in the most significant byte, so each 128-bit
  // literal below is one row of the familiar 16x16 S-box listing.
  localparam logic [0:255][7:0] SUB_BYTES_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:9][7:0] RCON_TABLE = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic int nk(input int key_bits);
    return key_bits / 32;
  endfunction

  function automatic int nr(input int key_bits);
    return key_bits / 32 + 6;
  endfunction

  // RotWord: cyclic left rotation by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_key_expander_if.sv
// Key-in / round-key-out handshake bundle of the key expander.
//   key_valid/key_ready/key_data : cipher key, accepted on valid && ready
//   rk_valid/rk_ready            : round key stream handshake
//   rk_data/rk_round/rk_last     : round key, its index, final-round flag
// The slave modport is the expander; the master modport is its environment.
interface aes_key_expander_if #(
  parameter int KEY_BITS = 128
);

  logic                key_valid;
  logic                key_ready;
  logic [KEY_BITS-1:0] key_data;
  logic                rk_valid;
  logic                rk_ready;
  logic [127:0]        rk_data;
  logic [3:0]          rk_round;
  logic                rk_last;

  modport master (
    output key_valid, key_data, rk_ready,
    input  key_ready, rk_valid, rk_data, rk_round, rk_last
  );

  modport slave (
    input  key_valid, key_data, rk_ready,
    output key_ready, rk_valid, rk_data, rk_round, rk_last
  );

endinterface

// File: rtl/aes_key_expander_sub_word.sv
// SubWord: applies the AES S-box to each byte of a 32-bit word.
//   din  : input word
//   dout : byte-wise substituted word
// Purely combinational; one instance is shared by both substitution paths.
module aes_sub_word
  import aes_model_pack::*;
(
  input  word_t din,
  output word_t dout
);

  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign dout[8*b +: 8] = SUB_BYTES_TABLE[din[8*b +: 8]];
  end

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES key schedule for 128/192/256-bit keys.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : aes_key_expander_if slave side
//         key_valid/key_ready/key_data  cipher key in (w0 in the MSBs)
//         rk_valid/rk_ready/rk_data     round keys out, round 0..Nr in order
//         rk_round/rk_last              round index and final-round flag
// One schedule word is produced per cycle. Words collect four at a time into
// a round key; a full collector stalls generation until the output register
// frees up, so at most one round key is buffered ahead of the output.
module aes_key_expander
  import aes_model_pack::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic clk,
  input  logic rst,
  aes_key_expander_if.slave bus
);

  localparam int NK = nk(KEY_BITS);
  localparam int NR = nr(KEY_BITS);
  localparam int NW = 4 * (NR + 1);

  localparam logic [5:0] NK_W      = 6'(NK);
  localparam logic [5:0] LAST_WORD = 6'(NW - 1);
  localparam logic [2:0] MOD_LAST  = 3'(NK - 1);
  localparam logic [3:0] NR_W      = 4'(NR);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  // Control state
  state_t     state, state_nxt;
  logic [5:0] word_idx;   // i: index of the next schedule word
  logic [2:0] mod_idx;    // i mod Nk, tracked alongside i
  logic [3:0] rcon_idx;   // i/Nk - 1 at the words that consume a round constant
  logic [3:0] round_cnt;  // round index of the next key sent to the output
  logic       col_full;

  // Datapath state
  word_t win [NK];        // win[0] = w[i-Nk], win[NK-1] = w[i-1]
  word_t col [4];

  // Output register
  logic         out_valid;
  logic [127:0] out_data;
  logic [3:0]   out_round;
  logic         out_last;

  // Handshake and flow control
  logic key_hs, out_free, gen_en, col_xfer, direct_load, out_load, out_done;

  assign key_hs      = bus.key_valid && (state == ST_IDLE);
  assign out_free    = !out_valid || bus.rk_ready;
  assign gen_en      = (state == ST_GEN) && (!col_full || out_free);
  assign col_xfer    = col_full && out_free;
  // The fourth word of a round key bypasses the collector when the output is
  // free, which is what gives round 0 on the cycle after w3 is produced.
  assign direct_load = gen_en && !col_full && (word_idx[1:0] == 2'd3) && out_free;
  assign out_load    = col_xfer || direct_load;
  assign out_done    = out_valid && bus.rk_ready && out_last;

  // Word generation
  word_t sub_in, sub_out, temp, new_word;

  assign sub_in = (mod_idx == '0) ? rot_word(win[NK-1]) : win[NK-1];

  aes_sub_word u_sub_word (
    .din  (sub_in),
    .dout (sub_out)
  );

  // NOTE: every combinational output gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    temp = win[NK-1];
    if (mod_idx == '0) begin
      temp = sub_out ^ {RCON_TABLE[rcon_idx], 24'h0};
    end else if (NK == 8 && mod_idx == 3'd4) begin
      temp = sub_out;
    end
    // While i < Nk the window is rotating the key words past its tail.
    new_word = (word_idx < NK_W) ? win[0] : (win[0] ^ temp);
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (bus.key_valid)                   state_nxt = ST_GEN;
      ST_GEN:   if (gen_en && word_idx == LAST_WORD) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_done)                        state_nxt = ST_IDLE;
      default:                                       state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      word_idx  <= '0;
      mod_idx   <= '0;
      rcon_idx  <= '0;
      round_cnt <= '0;
      col_full  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;

      if (key_hs) begin
        word_idx  <= '0;
        mod_idx   <= '0;
        rcon_idx  <= '0;
        round_cnt <= '0;
      end else if (gen_en) begin
        word_idx <= word_idx + 6'd1;
        mod_idx  <= (mod_idx == MOD_LAST) ? 3'd0 : mod_idx + 3'd1;
        if (mod_idx == '0 && word_idx >= NK_W) begin
          rcon_idx <= rcon_idx + 4'd1;
        end
      end

      if (col_xfer) begin
        col_full <= 1'b0;
      end else if (gen_en && word_idx[1:0] == 2'd3 && !out_free) begin
        col_full <= 1'b1;
      end

      if (out_load) begin
        out_valid <= 1'b1;
        out_data  <= col_xfer ? {col[0], col[1], col[2], col[3]}
                              : {col[0], col[1], col[2], new_word};
        out_round <= round_cnt;
        out_last  <= (round_cnt == NR_W);
        round_cnt <= round_cnt + 4'd1;
      end else if (bus.rk_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // NOTE: the window and collector are pure datapath storage with no reset;
  // they are always written before being read after a key handshake.
  always_ff @(posedge clk) begin
    if (key_hs) begin
      for (int j = 0; j < NK; j++) begin
        win[j] <= bus.key_data[KEY_BITS-1-32*j -: 32];
      end
    end else if (gen_en) begin
      for (int j = 0; j < NK - 1; j++) begin
        win[j] <= win[j+1];
      end
      win[NK-1] <= new_word;
    end
  end

  always_ff @(posedge clk) begin
    if (gen_en) begin
      col[word_idx[1:0]] <= new_word;
    end
  end

  assign bus.key_ready = (state == ST_IDLE);
  assign bus.rk_valid  = out_valid;
  assign bus.rk_data   = out_data;
  assign bus.rk_round  = out_round;
  assign bus.rk_last   = out_last;

endmodule

// File: tb/tb_aes_key_expander.sv
// Self-checking bench for aes_key_expander at all three key widths.
// The reference model is the textbook key expansion over plain arrays, with
// the S-box derived from GF(2^8) inversion plus the affine map, and pinned by
// published key schedule vectors.
module tb_aes_key_expander;

  typedef logic [31:0] w32_t;
  typedef struct packed {
    logic [127:0] data;
    logic [3:0]   round;
    logic         last;
  } rk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  bit   rand_rdy = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Per-instance views: index 0 = 128-bit, 1 = 192-bit, 2 = 256-bit
  logic [2:0]   kv = '0;
  logic [255:0] kd [3];
  logic [2:0]   kr, rv, rl;
  logic [127:0] rd [3];
  logic [3:0]   rrnd [3];

  aes_key_expander_if #(.KEY_BITS(128)) if128 ();
  aes_key_expander_if #(.KEY_BITS(192)) if192 ();
  aes_key_expander_if #(.KEY_BITS(256)) if256 ();

  aes_key_expander #(.KEY_BITS(128)) u128 (.clk(clk), .rst(rst), .bus(if128.slave));
  aes_key_expander #(.KEY_BITS(192)) u192 (.clk(clk), .rst(rst), .bus(if192.slave));
  aes_key_expander #(.KEY_BITS(256)) u256 (.clk(clk), .rst(rst), .bus(if256.slave));

  assign if128.key_valid = kv[0];
  assign if192.key_valid = kv[1];
  assign if256.key_valid = kv[2];
  assign if128.key_data  = kd[0][127:0];
  assign if192.key_data  = kd[1][191:0];
  assign if256.key_data  = kd[2];
  assign if128.rk_ready  = rdy;
  assign if192.rk_ready  = rdy;
  assign if256.rk_ready  = rdy;

  assign kr   = {if256.key_ready, if192.key_ready, if128.key_ready};
  assign rv   = {if256.rk_valid,  if192.rk_valid,  if128.rk_valid};
  assign rl   = {if256.rk_last,   if192.rk_last,   if128.rk_last};
  assign rd[0] = if128.rk_data;
  assign rd[1] = if192.rk_data;
  assign rd[2] = if256.rk_data;
  assign rrnd[0] = if128.rk_round;
  assign rrnd[1] = if192.rk_round;
  assign rrnd[2] = if256.rk_round;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sb [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic w32_t subw(input w32_t w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r = 8'h01;
    for (int t = 1; t < j; t++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h1b) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic void expand(input int kb, input logic [255:0] key, output w32_t w [60]);
    int   n;
    w32_t t;
    n = kb / 32;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < 4 * (n + 7); i++) begin
      if (i < n) begin
        w[i] = key[kb-1-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % n == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(i / n), 24'h0};
        else if (n > 6 && i % n == 4) t = subw(t);
        w[i] = w[i-n] ^ t;
      end
    end
  endfunction

  function automatic logic [127:0] round_key(input w32_t w [60], input int r);
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  rk_t  exp_q [3][$];
  logic [2:0] stall_prev = '0;
  rk_t  prev_out [3];
  int   got [3] = '{0, 0, 0};
  int   hs_count [3] = '{0, 0, 0};
  int   fin_cyc [3] = '{-1, -1, -1};
  bit   gap_chk = 1'b0;
  int   gap_seen = 0;

  task automatic push_expected(input int k, input logic [255:0] key);
    w32_t w [60];
    int   kb, nrr;
    kb  = 128 + 64 * k;
    nrr = kb / 32 + 6;
    expand(kb, key, w);
    for (int r = 0; r <= nrr; r++) begin
      exp_q[k].push_back('{data: round_key(w, r), round: 4'(r), last: (r == nrr)});
    end
  endtask

  initial forever begin
    rk_t cur, e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        exp_q[k].delete();
        stall_prev[k] = 1'b0;
        fin_cyc[k] = -1;
        continue;
      end
      if (kv[k] && kr[k]) begin
        if (gap_chk && k == 0 && fin_cyc[0] >= 0) begin
          check("next_key_at_F+1", 256'(cyc), 256'(fin_cyc[0] + 1));
          gap_seen++;
        end
        push_expected(k, kd[k]);
        hs_count[k]++;
      end
      cur = '{data: rd[k], round: rrnd[k], last: rl[k]};
      if (rv[k]) begin
        if (exp_q[k].size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rk_unexpected[%0d]: got round %0d with no key outstanding", k, rrnd[k]);
        end else begin
          e = exp_q[k][0];
          check($sformatf("rk_data[%0d] r%0d", k, e.round), 256'(cur.data), 256'(e.data));
          check($sformatf("rk_round[%0d]", k), 256'(cur.round), 256'(e.round));
          check($sformatf("rk_last[%0d] r%0d", k, e.round), 256'(cur.last), 256'(e.last));
          if (rdy) begin
            void'(exp_q[k].pop_front());
            got[k]++;
            if (rl[k]) fin_cyc[k] = cyc;
          end
        end
        if (stall_prev[k]) check($sformatf("rk_stable[%0d]", k), 256'(cur), 256'(prev_out[k]));
      end else if (stall_prev[k]) begin
        check($sformatf("rk_valid_held[%0d]", k), 256'(rv[k]), 256'(1));
      end
      stall_prev[k] = rv[k] && !rdy;
      prev_out[k] = cur;
    end
  end

  // rk_ready driver: constant high or 50% random per cycle
  initial forever begin
    @(posedge clk);
    #1;
    rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- directed helpers ----------------
  task automatic send_key(input int k, input logic [255:0] key);
    int   n = 0;
    logic r;
    @(posedge clk);
    #1;
    kv[k] = 1'b1;
    kd[k] = key;
    do begin
      @(negedge clk);
      r = kr[k];
      @(posedge clk);
      n++;
    end while (!r && n < 500);
    #1;
    kv[k] = 1'b0;
    check($sformatf("key_accepted[%0d]", k), 256'(r), 256'(1));
  endtask

  task automatic wait_round(input int k, input int r, input int max, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(rv[k] && rrnd[k] == 4'(r)) && n < max);
    check($sformatf("round_seen[%0d] r%0d", k, r), 256'(rv[k] && rrnd[k] == 4'(r)), 256'(1));
  endtask

  task automatic wait_idle(input int k, input int max);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(kr[k] && exp_q[k].size() == 0) && n < max);
    check($sformatf("drained[%0d]", k), 256'(kr[k] && exp_q[k].size() == 0), 256'(1));
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic run_rand(input int k);
    int start;
    for (int rep = 0; rep < 3; rep++) begin
      start = got[k];
      send_key(k, (rep == 0) ? K128 : rand_key());
      wait_idle(k, 4000);
      check($sformatf("key_count[%0d]", k), 256'(got[k] - start), 256'(k * 2 + 11));
    end
  endtask

  localparam logic [255:0] K128 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [255:0] K192 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    w32_t w [60];
    int   n, t0, hs0;
    for (int k = 0; k < 3; k++) kd[k] = '0;
    build_sbox();

    // Model pinned by published schedules
    expand(128, K128, w);
    check("model128_r1", 256'(round_key(w, 1)), 256'h a0fafe1788542cb123a339392a6c7605);
    check("model128_r10", 256'(round_key(w, 10)), 256'h d014f9a8c9ee2589e13f0cc8b6630ca6);
    expand(192, K192, w);
    check("model192_w6", 256'(w[6]), 256'h fe0c91f7);
    check("model192_r12", 256'(round_key(w, 12)), 256'h e98ba06f448c773c8ecc720401002202);
    expand(256, K256, w);
    check("model256_w8", 256'(w[8]), 256'h 9ba35411);
    check("model256_r14", 256'(round_key(w, 14)), 256'h fe4890d1e6188d0b046df344706c631e);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_rk_valid[%0d]", k), 256'(rv[k]), 256'(0));
      check($sformatf("rst_rk_data[%0d]", k), 256'(rd[k]), 256'(0));
      check($sformatf("rst_rk_round[%0d]", k), 256'(rrnd[k]), 256'(0));
      check($sformatf("rst_rk_last[%0d]", k), 256'(rl[k]), 256'(0));
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("key_ready_after_rst", 256'(kr), 256'(3'b111));

    // Known vectors with rk_ready held high: latency and literal outputs
    for (int k = 0; k < 3; k++) begin
      send_key(k, (k == 0) ? K128 : (k == 1) ? K192 : K256);
      wait_round(k, 0, 20, n);
      check($sformatf("r0_latency[%0d]", k), 256'(n), 256'(4));
      wait_round(k, 10 + 2 * k, 200, t0);
      check($sformatf("last_latency[%0d]", k), 256'(n + t0), 256'(4 + 4 * (10 + 2 * k)));
      check($sformatf("last_flag[%0d]", k), 256'(rl[k]), 256'(1));
      if (k == 0) check("r10_literal", 256'(rd[0]), 256'h d014f9a8c9ee2589e13f0cc8b6630ca6);
      if (k == 1) check("r12_literal", 256'(rd[1]), 256'h e98ba06f448c773c8ecc720401002202);
      if (k == 2) check("r14_literal", 256'(rd[2]), 256'h fe4890d1e6188d0b046df344706c631e);
      wait_idle(k, 50);
    end

    // Random backpressure on all widths at once
    rand_rdy = 1'b1;
    fork
      run_rand(0);
      run_rand(1);
      run_rand(2);
    join
    rand_rdy = 1'b0;
    @(posedge clk);

    // Reset while round 5 is on the output, then a fresh key
    send_key(0, rand_key());
    wait_round(0, 5, 100, n);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_rk_valid", 256'(rv[0]), 256'(0));
    check("midrst_key_ready", 256'(kr[0]), 256'(1));
    rst = 1'b0;
    send_key(0, rand_key());
    wait_round(0, 0, 20, n);
    check("post_rst_r0_latency", 256'(n), 256'(4));
    wait_idle(0, 200);

    // key_valid held high with key_data changing every cycle
    hs0 = hs_count[0];
    t0 = got[0];
    gap_chk = 1'b1;
    fin_cyc[0] = -1;
    @(posedge clk);
    #1;
    kv[0] = 1'b1;
    n = 0;
    while (hs_count[0] < hs0 + 2 && n < 500) begin
      kd[0] = rand_key();
      @(posedge clk);
      #1;
      n++;
    end
    kv[0] = 1'b0;
    check("held_valid_two_keys", 256'(hs_count[0] - hs0), 256'(2));
    wait_idle(0, 200);
    gap_chk = 1'b0;
    check("held_valid_gap_checked", 256'(gap_seen), 256'(1));
    check("held_valid_round_count", 256'(got[0] - t0), 256'(22));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
